ts_sync_lock: RTL and testbench
===============================

TS_SYNC_LOCK -- requirements
Module: ts_sync_lock

Interface
REQ-001 SHALL have parameter PKT_LEN, default 188, bytes per TS packet; legal range 8..255.
REQ-002 SHALL have parameter LOCK_REPS, default 5, consecutive sync bytes needed to lock; minimum 2.
REQ-003 SHALL have parameter LOSS_REPS, default 3, consecutive missed sync bytes needed to drop lock; minimum 1.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'h47, sync pattern.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 byte_in  input  8  stream byte.
REQ-008 byte_valid  input  1  byte_in qualifier.
REQ-009 byte_out  output  8  registered copy of byte_in.
REQ-010 valid  output  1  byte_out qualifier.
REQ-011 sync  output  1  high while locked, aligned to byte_out.
REQ-012 sop  output  1  marks the byte_out at packet index 0 while locked.
REQ-013 lost  output  1  one-cycle pulse on the byte that drops lock.

Function
REQ-014 Latency SHALL be exactly 1 cycle: byte_out, valid, sync, sop and lost for an accepted byte all appear on the cycle after byte_valid=1.
REQ-015 With byte_valid=0: valid=0, sop=0, lost=0; byte_out and sync hold; no state or counter advances.
REQ-016 Position counter pos ($clog2(PKT_LEN) bits) SHALL give the index of each accepted byte and wrap PKT_LEN-1 -> 0.
REQ-017 The FSM SHALL have three states: HUNT, VERIFY, LOCK.
REQ-018 In HUNT, a byte equal to SYNC_BYTE SHALL set pos for the next byte to 1, good to 1, and go to VERIFY; any other byte stays in HUNT.
REQ-019 In VERIFY at pos=0, SYNC_BYTE SHALL increment good, and the byte making good=LOCK_REPS SHALL go to LOCK; any other byte SHALL go to HUNT and clear good.
REQ-020 In LOCK at pos=0, SYNC_BYTE SHALL clear miss; any other byte SHALL increment miss.
REQ-021 When the increment makes miss=LOSS_REPS, the FSM SHALL go to HUNT and assert lost for that byte.
REQ-022 Below LOSS_REPS the FSM SHALL flywheel: remain in LOCK and keep pos counting.
REQ-023 sync for a byte SHALL equal (next state == LOCK); the byte completing lock SHALL carry sync=1 and sop=1.
REQ-024 The byte dropping lock SHALL carry sync=0 and sop=0.
REQ-025 sop SHALL be 1 for pos=0 bytes whose next state is LOCK, including flywheeled, corrupted sync positions.
REQ-026 Counters good and miss SHALL be $clog2(max+1) bits wide and SHALL never wrap, because they clear on state change.
REQ-027 The payload value SYNC_BYTE at pos≠0 SHALL be ignored in VERIFY and LOCK.

Reset
REQ-028 When rst=0 at a clock edge: state=HUNT; pos, good, miss=0; byte_out=8'h00; valid, sync, sop, lost=0.
REQ-029 Reset SHALL take priority over byte_valid.
REQ-030 A reset taken mid-lock SHALL require LOCK_REPS fresh sync bytes to relock.

Structure
REQ-031 The state encoding, SYNC_BYTE default and TS length constants (188, 204) SHALL live in the shared package ts_pkg.
REQ-032 The block SHALL be a single module with no sub-module.
REQ-033 Multi-channel use SHALL be a generate wrapper, ts_sync_lock_array, outside this block.

Verification
REQ-034 Defaults, clean packets with 0x47 every 188 bytes from byte 0 -> sync and sop rise with output of input byte 752; sop then every 188 valid outputs; lost never asserts.
REQ-035 Same stream with byte_valid toggling 1/0 -> identical sync/sop sequence counted in valid outputs; no output activity when valid=0.
REQ-036 After lock, one sync byte replaced by 0x00 -> sync stays 1 and sop asserts on it.
REQ-037 After lock, three consecutive sync bytes replaced by 0x00 -> sync falls and lost=1 for one cycle on the third; state is HUNT.
REQ-038 A 0x47 at payload index 100 preceding true alignment -> VERIFY, then HUNT on mismatch 188 bytes later; eventual lock on the true alignment.
REQ-039 PKT_LEN=204 -> lock on input byte 816; rst=0 for one cycle while locked -> all outputs 0 next cycle, relock after 5 further sync bytes.

Source files
------------

// File: rtl/ts_pkg.sv
// ts_pkg: shared TS sync constants (sync byte, 188/204 packet lengths) and FSM state encoding
package ts_pkg;
    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} ts_state_t;
    localparam logic [7:0] SYNC_DEFAULT = 8'h47;
    localparam int TS_LEN_188 = 188;
    localparam int TS_LEN_204 = 204;
endpackage

// File: rtl/ts_sync_lock_if.sv
// ts_sync_lock_if: byte stream bus; master drives byte_in/byte_valid, slave returns byte_out/valid/sync/sop/lost
interface ts_sync_lock_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       valid;
    logic       sync;
    logic       sop;
    logic       lost;
    modport master (output byte_in, byte_valid, input byte_out, valid, sync, sop, lost);
    modport slave (input byte_in, byte_valid, output byte_out, valid, sync, sop, lost);
endinterface

// File: rtl/ts_sync_lock.sv
// ts_sync_lock: TS packet sync hunt/verify/lock with flywheel; ports clk, rst (sync active-low), bus (slave: byte_in/byte_valid in, byte_out/valid/sync/sop/lost out, 1-cycle latency)
module ts_sync_lock
    import ts_pkg::*;
#(
    parameter int         PKT_LEN   = TS_LEN_188,
    parameter int         LOCK_REPS = 5,
    parameter int         LOSS_REPS = 3,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    ts_sync_lock_if.slave bus
);
    localparam int PW = $clog2(PKT_LEN);
    localparam int GW = $clog2(LOCK_REPS + 1);
    localparam int MW = $clog2(LOSS_REPS + 1);
    ts_state_t     state, state_n;
    logic [PW-1:0] pos, pos_n;
    logic [GW-1:0] good, good_n, good_inc;
    logic [MW-1:0] miss, miss_n, miss_inc;
    logic          lost_n, hit, at0;
    assign hit      = bus.byte_in == SYNC_BYTE;
    assign at0      = pos == '0;
    assign good_inc = good + 1'b1;
    assign miss_inc = miss + 1'b1;
    always_comb begin
        state_n = state;
        pos_n   = (pos == PW'(PKT_LEN - 1)) ? '0 : pos + 1'b1;
        good_n  = good;
        miss_n  = miss;
        lost_n  = 1'b0;
        case (state)
            HUNT: begin
                state_n = hit ? VERIFY : HUNT;
                pos_n   = hit ? PW'(1) : '0;
                good_n  = hit ? GW'(1) : '0;
            end
            VERIFY: if (at0) begin
                state_n = !hit ? HUNT : (good_inc == GW'(LOCK_REPS)) ? LOCK : VERIFY;
                good_n  = (hit && good_inc != GW'(LOCK_REPS)) ? good_inc : '0;
                miss_n  = '0;
                if (!hit) pos_n = '0;
            end
            LOCK: if (at0) begin
                miss_n = hit ? '0 : miss_inc;
                if (!hit && miss_inc == MW'(LOSS_REPS)) begin
                    state_n = HUNT;
                    lost_n  = 1'b1;
                    miss_n  = '0;
                    pos_n   = '0;
                end
            end
            default: state_n = HUNT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= HUNT;
            pos          <= '0;
            good         <= '0;
            miss         <= '0;
            bus.byte_out <= 8'h00;
            bus.valid    <= 1'b0;
            bus.sync     <= 1'b0;
            bus.sop      <= 1'b0;
            bus.lost     <= 1'b0;
        end else begin
            bus.valid <= bus.byte_valid;
            bus.sop   <= bus.byte_valid && at0 && state_n == LOCK;
            bus.lost  <= bus.byte_valid && lost_n;
            if (bus.byte_valid) begin
                state        <= state_n;
                pos          <= pos_n;
                good         <= good_n;
                miss         <= miss_n;
                bus.byte_out <= bus.byte_in;
                bus.sync     <= state_n == LOCK;
            end
        end
    end
endmodule

// File: tb/tb_ts_sync_lock.sv
// tb_ts_sync_lock: table vectors, spec scenarios and random stream on three ts_sync_lock configs vs an index-arithmetic model
module tb_ts_sync_lock;
    import ts_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    ts_sync_lock_if if0 ();
    ts_sync_lock_if if1 ();
    ts_sync_lock_if if2 ();
    ts_sync_lock u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    ts_sync_lock #(.PKT_LEN(TS_LEN_204)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    ts_sync_lock #(.PKT_LEN(8), .LOCK_REPS(3), .LOSS_REPS(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    logic [7:0]  din [3];
    logic        dv  [3];
    logic [11:0] obs [3];
    assign if0.byte_in    = din[0];
    assign if1.byte_in    = din[1];
    assign if2.byte_in    = din[2];
    assign if0.byte_valid = dv[0];
    assign if1.byte_valid = dv[1];
    assign if2.byte_valid = dv[2];
    assign obs[0] = {if0.valid, if0.sync, if0.sop, if0.lost, if0.byte_out};
    assign obs[1] = {if1.valid, if1.sync, if1.sop, if1.lost, if1.byte_out};
    assign obs[2] = {if2.valid, if2.sync, if2.sop, if2.lost, if2.byte_out};
    typedef struct {
        int         len, lr, ls, n, anchor, mode, good, miss;
        logic [7:0] bo;
        logic       sy;
    } mdl_t;
    mdl_t m [3];
    typedef struct {
        logic [7:0]  b;
        logic        v;
        int          reps;
        logic [11:0] exp;
    } vec_t;
    vec_t tv [19];
    int n_cmp = 0, n_bad = 0;
    int acc, first_sync, sop_cnt, sync_cnt, lost_cnt, lost_at;
    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%b sync=%b sop=%b lost=%b byte=%h, expected v=%b sync=%b sop=%b lost=%b byte=%h",
                     nm, act[11], act[10], act[9], act[8], act[7:0], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask
    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic reset_models();
        for (int i = 0; i < 3; i++) begin
            m[i].n = 0; m[i].anchor = 0; m[i].mode = 0; m[i].good = 0; m[i].miss = 0;
            m[i].bo = 8'h00; m[i].sy = 1'b0;
        end
    endtask
    // mode 0=searching, 1=candidate alignment, 2=locked; position is byte count since the anchor modulo len
    task automatic model_step(input int id, input logic [7:0] b, input logic v, output logic [11:0] e);
        int p;
        logic hit, lst;
        hit = (b == SYNC_DEFAULT);
        lst = 1'b0;
        if (!v) begin
            e = {1'b0, m[id].sy, 2'b00, m[id].bo};
            return;
        end
        p = (m[id].mode == 0) ? 0 : (m[id].n - m[id].anchor) % m[id].len;
        if (m[id].mode == 0) begin
            if (hit) begin m[id].mode = 1; m[id].anchor = m[id].n; m[id].good = 1; end
        end else if (p == 0) begin
            if (m[id].mode == 1) begin
                if (!hit) m[id].mode = 0;
                else begin
                    m[id].good = m[id].good + 1;
                    if (m[id].good == m[id].lr) begin m[id].mode = 2; m[id].miss = 0; end
                end
            end else begin
                m[id].miss = hit ? 0 : m[id].miss + 1;
                if (m[id].miss == m[id].ls) begin m[id].mode = 0; lst = 1'b1; end
            end
        end
        m[id].n = m[id].n + 1;
        m[id].sy = (m[id].mode == 2);
        m[id].bo = b;
        e = {1'b1, m[id].sy, (p == 0) && m[id].sy, lst, b};
    endtask
    task automatic clr_stats();
        acc = 0; first_sync = -1; sop_cnt = 0; sync_cnt = 0; lost_cnt = 0; lost_at = -1;
    endtask
    task automatic step(input int id, input logic [7:0] b, input logic v, input string nm);
        logic [11:0] e;
        din[id] = b;
        dv[id]  = v;
        model_step(id, b, v, e);
        @(posedge clk);
        #1;
        check(nm, obs[id], e);
        dv[id] = 1'b0;
        if (obs[id][11]) begin
            if (obs[id][10] && first_sync < 0) first_sync = acc;
            if (obs[id][10]) sync_cnt++;
            if (obs[id][9]) sop_cnt++;
            if (obs[id][8]) begin lost_cnt++; lost_at = acc; end
            acc++;
        end
    endtask
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin din[i] = SYNC_DEFAULT; dv[i] = 1'b1; end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_dut%0d", i), obs[i], 12'h000);
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        rst = 1'b1;
        reset_models();
    endtask
    function automatic logic [7:0] payload();
        logic [7:0] b;
        b = 8'($urandom_range(0, 254));
        return (b == SYNC_DEFAULT) ? 8'hFF : b;
    endfunction
    task automatic send_pkts(input int id, input int n_pk, input int bad_lo, input int bad_hi, input bit toggle);
        logic [7:0] b;
        for (int k = 0; k < n_pk; k++)
            for (int i = 0; i < m[id].len; i++) begin
                b = (i == 0 && !(k >= bad_lo && k <= bad_hi)) ? SYNC_DEFAULT : payload();
                if (toggle) step(id, 8'h5A, 1'b0, "idle_gap");
                step(id, b, 1'b1, "stream");
            end
    endtask
    initial begin
        int rp;
        logic [7:0] b;
        logic v;
        m[0].len = 188; m[0].lr = 5; m[0].ls = 3;
        m[1].len = 204; m[1].lr = 5; m[1].ls = 3;
        m[2].len = 8;   m[2].lr = 3; m[2].ls = 2;
        for (int i = 0; i < 3; i++) begin din[i] = 8'h00; dv[i] = 1'b0; end
        tv = '{'{8'h47, 1'b1, 1, 12'h847}, '{8'h00, 1'b1, 7, 12'h800}, '{8'h47, 1'b1, 1, 12'h847},
               '{8'h11, 1'b1, 3, 12'h811}, '{8'h00, 1'b0, 2, 12'h011}, '{8'h47, 1'b1, 1, 12'h847},
               '{8'h22, 1'b1, 3, 12'h822}, '{8'h47, 1'b1, 1, 12'hE47}, '{8'h33, 1'b1, 7, 12'hC33},
               '{8'h00, 1'b0, 1, 12'h433}, '{8'h00, 1'b1, 1, 12'hE00}, '{8'h33, 1'b1, 7, 12'hC33},
               '{8'h47, 1'b1, 1, 12'hE47}, '{8'h33, 1'b1, 7, 12'hC33}, '{8'h00, 1'b1, 1, 12'hE00},
               '{8'h33, 1'b1, 7, 12'hC33}, '{8'h00, 1'b1, 1, 12'h900}, '{8'h33, 1'b1, 2, 12'h833},
               '{8'h00, 1'b0, 1, 12'h033}};
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 19; i++)
            for (int r = 0; r < tv[i].reps; r++) begin
                step(2, tv[i].b, tv[i].v, "table_model");
                check($sformatf("table_vec%0d", i), obs[2], tv[i].exp);
            end
        clr_stats();
        send_pkts(0, 7, -1, -2, 1'b0);
        check_int("clean_lock_index", first_sync, 752);
        check_int("clean_sop_count", sop_cnt, 3);
        check_int("clean_lost_count", lost_cnt, 0);
        clr_stats();
        send_pkts(0, 3, 1, 1, 1'b0);
        check_int("flywheel_sync_count", sync_cnt, 564);
        check_int("flywheel_sop_count", sop_cnt, 3);
        check_int("flywheel_lost_count", lost_cnt, 0);
        clr_stats();
        send_pkts(0, 4, 0, 2, 1'b0);
        check_int("loss_lost_count", lost_cnt, 1);
        check_int("loss_lost_index", lost_at, 376);
        check_int("loss_sync_count", sync_cnt, 376);
        check_int("loss_sop_count", sop_cnt, 2);
        do_reset();
        clr_stats();
        send_pkts(0, 6, -1, -2, 1'b1);
        check_int("toggle_lock_index", first_sync, 752);
        check_int("toggle_sop_count", sop_cnt, 2);
        do_reset();
        clr_stats();
        step(0, SYNC_DEFAULT, 1'b1, "false_sync");
        for (int i = 0; i < 87; i++) step(0, payload(), 1'b1, "false_payload");
        send_pkts(0, 7, -1, -2, 1'b0);
        check_int("false_lock_index", first_sync, 1028);
        check_int("false_sop_count", sop_cnt, 2);
        check_int("false_lost_count", lost_cnt, 0);
        do_reset();
        clr_stats();
        send_pkts(1, 5, -1, -2, 1'b0);
        check_int("len204_lock_index", first_sync, 816);
        do_reset();
        clr_stats();
        send_pkts(1, 5, -1, -2, 1'b0);
        check_int("len204_relock_index", first_sync, 816);
        check_int("len204_relock_sop", sop_cnt, 1);
        do_reset();
        rp = 0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 399) == 0) begin do_reset(); rp = 0; end
            if ($urandom_range(0, 299) == 0) rp = $urandom_range(0, 7);
            v = $urandom_range(0, 3) != 0;
            b = 8'($urandom_range(0, 255));
            if (v && rp == 0 && $urandom_range(0, 9) != 0) b = SYNC_DEFAULT;
            else if ($urandom_range(0, 15) == 0) b = SYNC_DEFAULT;
            if (v) rp = (rp + 1) % 8;
            step(2, b, v, "random");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
